slave_port_arbiter: RTL and testbench

//  One instance per slave. Receives the one-hot request bit that each master's request

---
 rtl/slave_port_arbiter_if.sv | 36 +++
 rtl/slave_port_arbiter.sv | 139 +++++++++++++
 tb/tb_slave_port_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slave_port_arbiter_if.sv
// Bus bundle between the competing masters, the per-slave arbiter and the slave.
//  master modport : arbiter view (it drives the granted transaction toward the slave)
//                   in : master_req/addr/cmd/wdata, slave_ack, slave_rdata
//                   out: master_ack, master_rdata, grant_id, slave_req/addr/cmd/wdata
//  slave modport  : environment view (masters' request decoders plus the slave itself)
interface slave_port_arbiter_if #(
    parameter int unsigned QTY_OF_MASTERS = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32
);
    localparam int unsigned GW = $clog2(QTY_OF_MASTERS);

    logic [QTY_OF_MASTERS-1:0]        master_req;
    logic [QTY_OF_MASTERS*ADDR_W-1:0] master_addr;
    logic [QTY_OF_MASTERS-1:0]        master_cmd;
    logic [QTY_OF_MASTERS*DATA_W-1:0] master_wdata;
    logic [QTY_OF_MASTERS-1:0]        master_ack;
    logic [DATA_W-1:0]                master_rdata;
    logic [GW-1:0]                    grant_id;
    logic                             slave_req;
    logic [ADDR_W-1:0]                slave_addr;
    logic                             slave_cmd;
    logic [DATA_W-1:0]                slave_wdata;
    logic                             slave_ack;
    logic [DATA_W-1:0]                slave_rdata;

    modport master (
        input  master_req, master_addr, master_cmd, master_wdata, slave_ack, slave_rdata,
        output master_ack, master_rdata, grant_id, slave_req, slave_addr, slave_cmd, slave_wdata
    );

    modport slave (
        output master_req, master_addr, master_cmd, master_wdata, slave_ack, slave_rdata,
        input  master_ack, master_rdata, grant_id, slave_req, slave_addr, slave_cmd, slave_wdata
    );
endinterface

// File: rtl/slave_port_arbiter.sv
// Round-robin arbiter owning one slave. Grants one requesting master at a time,
// latches its addr/cmd/wdata toward the slave, waits for slave_ack, then pulses
// master_ack to the winner with the captured read data.
//  clk, rst_n : clock and asynchronous active-low reset
//  bus        : slave_port_arbiter_if.master (master request side + slave side)
module slave_port_arbiter #(
    parameter int unsigned QTY_OF_MASTERS = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    slave_port_arbiter_if.master bus
);
    localparam int unsigned M  = QTY_OF_MASTERS;
    localparam int unsigned GW = $clog2(QTY_OF_MASTERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     rr_q, rr_d;
    logic [M-1:0]      served_q, served_d, served_set;
    logic              slave_req_q, slave_req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cmd_q, cmd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [M-1:0]      ack_q, ack_d;

    logic [M-1:0]      eligible;
    logic              win_found;
    logic [GW-1:0]     win_idx;
    logic [GW-1:0]     cand;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_q        <= '0;
            served_q    <= '0;
            slave_req_q <= 1'b0;
            addr_q      <= '0;
            cmd_q       <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            served_q    <= served_d;
            slave_req_q <= slave_req_d;
            addr_q      <= addr_d;
            cmd_q       <= cmd_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
        end
    end

    // Next-state, winner search and next output values
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        served_set  = '0;
        slave_req_d = slave_req_q;
        addr_d      = addr_q;
        cmd_d       = cmd_q;
        wdata_d     = wdata_q;
        rdata_d     = '0;
        ack_d       = '0;
        win_found   = 1'b0;
        win_idx     = '0;
        cand        = '0;

        // A master already served must drop its request before it is eligible again
        eligible = bus.master_req & ~served_q;

        // First eligible master starting at rr_q, wrapping modulo M
        for (int unsigned k = 0; k < M; k++) begin
            cand = GW'((32'(rr_q) + k) % M);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = BUSY;
                    grant_d     = win_idx;
                    slave_req_d = 1'b1;
                    addr_d      = bus.master_addr[32'(win_idx)*ADDR_W +: ADDR_W];
                    cmd_d       = bus.master_cmd[win_idx];
                    wdata_d     = bus.master_wdata[32'(win_idx)*DATA_W +: DATA_W];
                end else begin
                    slave_req_d = 1'b0;
                end
            end
            BUSY: begin
                if (bus.slave_ack) begin
                    state_d     = RESP;
                    slave_req_d = 1'b0;
                    rr_d        = (grant_q == GW'(M - 1)) ? '0 : grant_q + GW'(1);
                    ack_d       = M'(1) << grant_q;
                    rdata_d     = bus.slave_rdata;
                end
            end
            RESP: begin
                state_d             = IDLE;
                served_set[grant_q] = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                slave_req_d = 1'b0;
            end
        endcase

        // A low request clears the served bit, even in the cycle it is being set
        served_d = (served_q | served_set) & bus.master_req;
    end

    assign bus.master_ack   = ack_q;
    assign bus.master_rdata = rdata_q;
    assign bus.grant_id     = grant_q;
    assign bus.slave_req    = slave_req_q;
    assign bus.slave_addr   = addr_q;
    assign bus.slave_cmd    = cmd_q;
    assign bus.slave_wdata  = wdata_q;

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Self-checking bench for slave_port_arbiter: directed scenarios plus a randomized
// run compared cycle by cycle against a transaction-level reference model.
module tb_slave_port_arbiter;
    localparam int unsigned M  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned GW = 2;
    localparam int unsigned VW = 1 + GW + AW + 1 + DW + M + DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    slave_port_arbiter_if #(.QTY_OF_MASTERS(M), .ADDR_W(AW), .DATA_W(DW)) bus ();

    slave_port_arbiter #(.QTY_OF_MASTERS(M), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: what the next cycle should look like, tracked per transaction
    int              m_phase;   // 0 waiting for a request, 1 slave working, 2 reply
    int              m_grant;
    int              m_ptr;
    logic [M-1:0]    m_served;
    logic            m_sreq;
    logic [AW-1:0]   m_addr;
    logic            m_cmd;
    logic [DW-1:0]   m_wdata;
    logic [M-1:0]    m_ack;
    logic [DW-1:0]   m_rdata;

    task automatic model_reset();
        m_phase = 0; m_grant = 0; m_ptr = 0; m_served = '0; m_sreq = 1'b0;
        m_addr = '0; m_cmd = 1'b0; m_wdata = '0; m_ack = '0; m_rdata = '0;
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        logic [M-1:0] served_n;
        logic [M-1:0] elig;
        int w;
        served_n = m_served;
        elig     = bus.master_req & ~m_served;
        m_ack    = '0;
        m_rdata  = '0;
        if (m_phase == 0) begin
            w = -1;
            for (int k = 0; k < int'(M); k++)
                if (w < 0 && elig[(m_ptr + k) % M]) w = (m_ptr + k) % M;
            if (w >= 0) begin
                m_phase = 1; m_grant = w; m_sreq = 1'b1;
                m_addr  = bus.master_addr[w*AW +: AW];
                m_cmd   = bus.master_cmd[w];
                m_wdata = bus.master_wdata[w*DW +: DW];
            end
        end else if (m_phase == 1) begin
            if (bus.slave_ack) begin
                m_phase = 2; m_sreq = 1'b0; m_ptr = (m_grant + 1) % M;
                m_ack   = M'(1) << m_grant;
                m_rdata = bus.slave_rdata;
            end
        end else begin
            m_phase = 0;
            served_n[m_grant] = 1'b1;
        end
        m_served = served_n & bus.master_req;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.master_req = '0; bus.master_addr = '0; bus.master_cmd = '0;
        bus.master_wdata = '0; bus.slave_ack = 1'b0; bus.slave_rdata = '0;
    endtask

    // Drain any transaction in flight and leave the block idle with served bits clear
    task automatic settle();
        bus.master_req = '0;
        bus.slave_ack  = 1'b1;
        repeat (3) tick();
        bus.slave_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({bus.master_ack, bus.master_rdata, bus.grant_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_master_side got ack=%b rdata=%h gid=%0d want 0",
                     bus.master_ack, bus.master_rdata, bus.grant_id);
        end
        n_cmp++;
        if ({bus.slave_req, bus.slave_addr, bus.slave_cmd, bus.slave_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_slave_side got req=%b addr=%h cmd=%b wdata=%h want 0",
                     bus.slave_req, bus.slave_addr, bus.slave_cmd, bus.slave_wdata);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        int order[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [M-1:0] drop_pend;
        drop_pend = '0;
        for (int i = 0; i < int'(M); i++) begin
            bus.master_addr[i*AW +: AW]  = AW'(32'h100 + i);
            bus.master_wdata[i*DW +: DW] = DW'(32'h200 + i);
        end
        bus.slave_ack   = 1'b1;
        bus.master_req  = '1;
        for (int c = 0; c < 60 && order.size() < 5; c++) begin
            tick();
            bus.master_req = ~drop_pend;
            drop_pend      = bus.master_ack;
            for (int i = 0; i < int'(M); i++)
                if (bus.master_ack[i]) order.push_back(i);
        end
        n_cmp++;
        if (order.size() < 5) begin
            n_fail++;
            $display("FAIL rr_timeout got %0d grants want 5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (order[i] !== exp_order[i]) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d] got %0d want %0d", i, order[i], exp_order[i]);
                end
            end
        end
        settle();
    endtask

    task automatic test_single();
        bus.master_addr[2*AW +: AW]  = 32'h2000_0040;
        bus.master_wdata[2*DW +: DW] = 32'h1111_2222;
        bus.master_cmd  = 4'b0000;
        bus.master_req  = 4'b0100;                  // c0
        tick();                                     // c1
        n_cmp++;
        if ({bus.slave_req, bus.grant_id, bus.slave_addr} !== {1'b1, 2'd2, 32'h2000_0040}) begin
            n_fail++;
            $display("FAIL single_c1 got req=%b gid=%0d addr=%h want 1/2/20000040",
                     bus.slave_req, bus.grant_id, bus.slave_addr);
        end
        tick();                                     // c2
        n_cmp++;
        if ({bus.slave_req, bus.master_ack} !== {1'b1, 4'b0000}) begin
            n_fail++;
            $display("FAIL single_c2 got req=%b ack=%b want 1/0000", bus.slave_req, bus.master_ack);
        end
        tick();                                     // c3
        bus.slave_ack   = 1'b1;
        bus.slave_rdata = 32'hA5;
        n_cmp++;
        if ({bus.slave_req, bus.grant_id} !== {1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL single_c3 got req=%b gid=%0d want 1/2", bus.slave_req, bus.grant_id);
        end
        tick();                                     // c4
        bus.slave_ack  = 1'b0;
        bus.master_req = 4'b0000;
        n_cmp++;
        if ({bus.master_ack, bus.master_rdata, bus.slave_req} !== {4'b0100, 32'hA5, 1'b0}) begin
            n_fail++;
            $display("FAIL single_c4 got ack=%b rdata=%h req=%b want 0100/a5/0",
                     bus.master_ack, bus.master_rdata, bus.slave_req);
        end
        tick();                                     // c5
        n_cmp++;
        if ({bus.master_ack, bus.master_rdata, bus.slave_req, bus.grant_id} !==
            {4'b0000, 32'h0, 1'b0, 2'd2}) begin
            n_fail++;
            $display("FAIL single_c5 got ack=%b rdata=%h req=%b gid=%0d want 0/0/0/2",
                     bus.master_ack, bus.master_rdata, bus.slave_req, bus.grant_id);
        end
        settle();
    endtask

    task automatic test_held_request();
        int acks = 0;
        int late_reqs = 0;
        bus.slave_ack  = 1'b1;
        bus.master_req = 4'b0010;
        repeat (12) begin
            tick();
            if (acks > 0 && bus.slave_req) late_reqs++;
            if (bus.master_ack != '0) acks++;
        end
        n_cmp++;
        if (acks !== 1) begin
            n_fail++;
            $display("FAIL held_ack_count got %0d want 1", acks);
        end
        n_cmp++;
        if (late_reqs !== 0) begin
            n_fail++;
            $display("FAIL held_regrant got %0d slave_req cycles want 0", late_reqs);
        end
        bus.master_req = 4'b0000;
        tick();
        bus.master_req = 4'b0010;
        tick();
        n_cmp++;
        if ({bus.slave_req, bus.grant_id} !== {1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL held_rearm got req=%b gid=%0d want 1/1", bus.slave_req, bus.grant_id);
        end
        settle();
    endtask

    task automatic test_latch();
        bus.slave_ack = 1'b0;
        bus.master_addr[3*AW +: AW]  = 32'hCAFE_0003;
        bus.master_wdata[3*DW +: DW] = 32'hDEAD_BEEF;
        bus.master_cmd = 4'b1000;
        bus.master_req = 4'b1000;
        tick();                                     // BUSY
        bus.master_addr[3*AW +: AW]  = 32'h0BAD_0BAD;
        bus.master_wdata[3*DW +: DW] = 32'h1234_5678;
        bus.master_cmd = 4'b0000;
        tick();
        tick();
        n_cmp++;
        if ({bus.slave_req, bus.slave_addr, bus.slave_cmd, bus.slave_wdata} !==
            {1'b1, 32'hCAFE_0003, 1'b1, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL latch got req=%b addr=%h cmd=%b wdata=%h want 1/cafe0003/1/deadbeef",
                     bus.slave_req, bus.slave_addr, bus.slave_cmd, bus.slave_wdata);
        end
        settle();
    endtask

    task automatic test_reset_mid_busy();
        int stray = 0;
        bus.slave_ack  = 1'b1;
        bus.master_req = 4'b0010;                   // serve master 1 so the pointer moves to 2
        tick();
        tick();
        bus.master_req = 4'b0000;
        bus.slave_ack  = 1'b0;
        tick();
        bus.master_req = 4'b1100;
        tick();                                     // BUSY on master 2
        n_cmp++;
        if ({bus.slave_req, bus.grant_id} !== {1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL rst_pre got req=%b gid=%0d want 1/2", bus.slave_req, bus.grant_id);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.slave_req, bus.grant_id, bus.slave_addr, bus.master_ack, bus.master_rdata} !== '0) begin
            n_fail++;
            $display("FAIL rst_async got req=%b gid=%0d addr=%h ack=%b want all 0",
                     bus.slave_req, bus.grant_id, bus.slave_addr, bus.master_ack);
        end
        bus.slave_ack = 1'b1;
        repeat (2) begin
            tick();
            if (bus.master_ack != '0) stray++;
        end
        bus.slave_ack  = 1'b0;
        bus.master_req = 4'b1001;
        rst_n = 1'b1;
        tick();
        if (bus.master_ack != '0) stray++;
        n_cmp++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL rst_no_ack got %0d ack pulses want 0", stray);
        end
        n_cmp++;
        if ({bus.slave_req, bus.grant_id} !== {1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL rst_ptr got req=%b gid=%0d want 1/0", bus.slave_req, bus.grant_id);
        end
        settle();
    endtask

    task automatic test_spurious_ack();
        int bad = 0;
        bus.master_req = 4'b0000;
        bus.slave_ack  = 1'b1;
        repeat (3) begin
            tick();
            if (bus.master_ack != '0 || bus.slave_req) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL spurious_idle got %0d bad cycles want 0", bad);
        end
        bus.slave_ack  = 1'b0;
        bus.master_req = 4'b0100;
        tick();
        tick();
        n_cmp++;
        if ({bus.slave_req, bus.grant_id, bus.master_ack} !== {1'b1, 2'd2, 4'b0000}) begin
            n_fail++;
            $display("FAIL spurious_after got req=%b gid=%0d ack=%b want 1/2/0000",
                     bus.slave_req, bus.grant_id, bus.master_ack);
        end
        settle();
    endtask

    task automatic test_random();
        logic [VW-1:0] exp_v;
        logic [VW-1:0] act_v;
        int errs = 0;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        model_reset();
        rst_n = 1'b1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < int'(M); i++) begin
                if ($urandom_range(3) == 0) bus.master_req[i] = ~bus.master_req[i];
                bus.master_addr[i*AW +: AW]  = AW'($urandom());
                bus.master_wdata[i*DW +: DW] = DW'($urandom());
            end
            bus.master_cmd  = M'($urandom());
            bus.slave_ack   = ($urandom_range(1) == 1);
            bus.slave_rdata = DW'($urandom());
            model_step();
            tick();
            exp_v = {m_sreq, GW'(m_grant), m_addr, m_cmd, m_wdata, m_ack, m_rdata};
            act_v = {bus.slave_req, bus.grant_id, bus.slave_addr, bus.slave_cmd,
                     bus.slave_wdata, bus.master_ack, bus.master_rdata};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle%0d got %h want %h", c, act_v, exp_v);
            end
        end
        settle();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_round_robin();
        test_single();
        test_held_request();
        test_latch();
        test_reset_mid_busy();
        test_spurious_ack();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
